// File: rtl/axi_lite_arbiter.sv
// Two-port requester arbiter feeding one AXI4-Lite master; one transaction in flight.
// Latency: ack four cycles after req (grant, AW/W, B, ack) with an immediately-ready slave.
// Backpressure: holds each AXI valid until its handshake and waits indefinitely for B/R.
//
// Ports:
//   ACLK, ARESET (async, active-low)
//   req/we/addr/wdata/wstrb : per-port request and payload, port k in slice k
//   ack/rdata/resp          : one-cycle completion pulse per port, held read data and response
//   grant/busy              : one-hot bus owner (0 when idle), FSM not idle
//   AW*/W*/B*/AR*/R*        : AXI4-Lite master channel signals
module axi_lite_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [1:0]            req,
  input  logic [1:0]            we,
  input  logic [2*ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0]   wdata,
  input  logic [2*DATA_W/8-1:0] wstrb,
  output logic [1:0]            ack,
  output logic [DATA_W-1:0]     rdata,
  output logic [1:0]            resp,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  AWVALID,
  output logic [ADDR_W-1:0]     AWADDR,
  output logic                  WVALID,
  output logic [DATA_W-1:0]     WDATA,
  output logic [DATA_W/8-1:0]   WSTRB,
  output logic                  BREADY,
  output logic                  ARVALID,
  output logic [ADDR_W-1:0]     ARADDR,
  output logic                  RREADY,
  input  logic                  AWREADY,
  input  logic                  WREADY,
  input  logic                  BVALID,
  input  logic [1:0]            BRESP,
  input  logic                  ARREADY,
  input  logic                  RVALID,
  input  logic [DATA_W-1:0]     RDATA,
  input  logic [1:0]            RRESP
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          grant_q, grant_d;
  logic                last_q, last_d;     // index of the port granted most recently
  logic [1:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          resp_q, resp_d;
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                bready_q, bready_d;
  logic                arvalid_q, arvalid_d;
  logic                rready_q, rready_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [ADDR_W-1:0]   araddr_q, araddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;

  logic [1:0]          elig;
  logic                win;
  logic                aw_done;
  logic                w_done;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    ack_d     = 2'b00;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    awaddr_d  = awaddr_q;
    araddr_d  = araddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    // A port is masked during its own ack cycle so a held req is not re-granted
    // before the requester has seen the completion.
    elig      = req & ~ack_q;
    win       = 1'b0;
    aw_done   = 1'b0;
    w_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (elig != 2'b00) begin
          win     = (elig == 2'b11) ? ~last_q : elig[1];
          grant_d = win ? 2'b10 : 2'b01;
          last_d  = win;
          if (we[win]) begin
            awaddr_d  = win ? addr[ADDR_W +: ADDR_W]   : addr[0 +: ADDR_W];
            wdata_d   = win ? wdata[DATA_W +: DATA_W]  : wdata[0 +: DATA_W];
            wstrb_d   = win ? wstrb[STRB_W +: STRB_W]  : wstrb[0 +: STRB_W];
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            araddr_d  = win ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR_ADDR: begin
        // Each channel is done once its valid has already dropped or completes now.
        aw_done = !awvalid_q || AWREADY;
        w_done  = !wvalid_q  || WREADY;
        if (awvalid_q && AWREADY) awvalid_d = 1'b0;
        if (wvalid_q  && WREADY)  wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = WR_RESP;
        end
      end

      WR_RESP: begin
        if (BVALID && bready_q) begin
          resp_d   = BRESP;
          ack_d    = grant_q;
          grant_d  = 2'b00;
          bready_d = 1'b0;
          state_d  = IDLE;
        end
      end

      RD_ADDR: begin
        if (arvalid_q && ARREADY) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (RVALID && rready_q) begin
          rdata_d  = RDATA;
          resp_d   = RRESP;
          ack_d    = grant_q;
          grant_d  = 2'b00;
          rready_d = 1'b0;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;  // port 0 wins the first tie
      ack_q     <= 2'b00;
      rdata_q   <= '0;
      resp_q    <= 2'b00;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      ack_q     <= ack_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awaddr_q  <= awaddr_d;
      araddr_q  <= araddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

  assign ack     = ack_q;
  assign rdata   = rdata_q;
  assign resp    = resp_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);
  assign AWVALID = awvalid_q;
  assign AWADDR  = awaddr_q;
  assign WVALID  = wvalid_q;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign BREADY  = bready_q;
  assign ARVALID = arvalid_q;
  assign ARADDR  = araddr_q;
  assign RREADY  = rready_q;

endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, requester and AXI address width.
REQ-002 Parameter: DATA_W, 32, requester and AXI data width; DATA_W/8 strobe bits.
REQ-003 ACLK  in  1  clock; all state on rising edge.
REQ-004 ARESET  in  1  reset, asynchronous, active-low.
REQ-005 req  in  2  per-port request; bit k = port k.
REQ-006 we  in  2  per-port direction; 1 = write, 0 = read.
REQ-007 addr  in  2*ADDR_W  per-port address; port k at [k*ADDR_W +: ADDR_W].
REQ-008 wdata  in  2*DATA_W  per-port write data, same packing.
REQ-009 wstrb  in  2*DATA_W/8  per-port byte strobes, same packing.
REQ-010 ack  out  2  per-port one-cycle completion pulse.
REQ-011 rdata  out  DATA_W  read data of the completing transaction.
REQ-012 resp  out  2  BRESP/RRESP of the completing transaction.
REQ-013 grant  out  2  one-hot owner of the bus; 0 when idle.
REQ-014 busy  out  1  high when FSM is not IDLE.
REQ-015 AWVALID/AWADDR/WVALID/WDATA/WSTRB/BREADY/ARVALID/ARADDR/RREADY  out  1/ADDR_W/1/DATA_W/DATA_W/8/1/1/ADDR_W/1  AXI4-Lite master outputs.
REQ-016 AWREADY/WREADY/BVALID/BRESP/ARREADY/RVALID/RDATA/RRESP  in  1/1/1/2/1/1/DATA_W/2  AXI4-Lite master inputs.

Function
REQ-017 FSM states SHALL be IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA; one transaction outstanding at a time.
REQ-018 Requester SHALL hold req and payload stable until its ack; arbiter SHALL NOT depend on payload after the grant cycle.
REQ-019 IDLE: port k is eligible if req[k]=1 and ack[k]=0 (masks re-grant in the ack cycle).
REQ-020 Arbitration: single eligible port wins; both eligible -> port not granted last wins (round-robin); pointer updates on each grant.
REQ-021 On grant, payload SHALL be latched into internal registers, grant set one-hot, FSM -> WR_ADDR (we=1) or RD_ADDR (we=0).
REQ-022 WR_ADDR: AWVALID and WVALID SHALL both assert in the first cycle of the state (one cycle after grant), driven from latched registers.
REQ-023 AWVALID SHALL drop the cycle after AWVALID&AWREADY; WVALID likewise on WVALID&WREADY; independent, any order or same cycle.
REQ-024 When both handshakes are done, FSM -> WR_RESP with BREADY=1; BREADY SHALL be 0 in all other states.
REQ-025 WR_RESP: on BVALID&BREADY -> resp<=BRESP, ack[grant]=1 next cycle, grant<=0, BREADY<=0, FSM -> IDLE.
REQ-026 RD_ADDR: ARVALID held until ARVALID&ARREADY, then FSM -> RD_DATA with RREADY=1; RREADY SHALL be 0 in all other states.
REQ-027 RD_DATA: on RVALID&RREADY -> rdata<=RDATA, resp<=RRESP, ack[grant]=1 next cycle, grant<=0, RREADY<=0, FSM -> IDLE.
REQ-028 rdata/resp SHALL hold until the next completion; rdata unchanged on write completion.
REQ-029 ack SHALL be high exactly one cycle per transaction; never both bits.
REQ-030 No timeout: FSM waits indefinitely for slave handshakes.
REQ-031 BVALID/RVALID arriving in states where the matching ready is 0 SHALL be ignored.
REQ-032 Minimum write latency: grant cycle + 1 addr/data cycle + 1 response cycle; ack in the 4th cycle after req seen; a new grant is possible in the ack cycle (other port).

Reset
REQ-033 ARESET=0 SHALL immediately force: state IDLE, all AXI valid/ready outputs 0, AWADDR/ARADDR/WDATA/WSTRB 0, ack 0, grant 0, busy 0, rdata 0, resp 0, round-robin pointer so port 0 wins first tie.
REQ-034 Reset mid-transaction SHALL abandon it with no ack; after release arbitration restarts from IDLE.

Verification
REQ-035 Port0 write addr 0x10, data 0xA5A5_0001, strb 0xF, slave ready immediately, BRESP=00 -> AW/W same cycle, ack=2'b01 once, resp=00.
REQ-036 Port1 read addr 0x10 after REQ-035 write, RDATA=0xA5A5_0001, RRESP=00 -> ack=2'b10, rdata=0xA5A5_0001.
REQ-037 Both ports req continuously after reset -> grant order 0,1,0,1; no port acked twice consecutively.
REQ-038 WREADY 3 cycles before AWREADY -> WVALID drops first, AWVALID holds; BREADY rises only after both handshakes.
REQ-039 ARESET low in RD_DATA while RVALID=0 -> RREADY=0, grant=0, no ack; next read completes normally.
REQ-040 Slave returns BRESP=2'b10 -> resp=2'b10 with ack; arbiter returns to IDLE.
